// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP1,
        TX_STOP2
    } tx_state_t;

    localparam logic [1:0] DATA_BITS_5 = 2'd0;
    localparam logic [1:0] DATA_BITS_6 = 2'd1;
    localparam logic [1:0] DATA_BITS_7 = 2'd2;
    localparam logic [1:0] DATA_BITS_8 = 2'd3;

    function automatic logic parity_of(
        input logic [7:0] data,
        input logic [1:0] data_bits,
        input logic       even
    );
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(data_bits) + 5) acc ^= data[i];
        end
        return even ? acc : ~acc;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_fifo.sv
// Synchronous FIFO with occupancy count; writes while full are dropped.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];
    assign level   = count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter, 5-8 data bits, optional parity, 1/2 stop bits.
// Define UART_TX_CTS_EN to add the cts_n_i flow-control input.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLOCK_DIVIDER_WIDTH = 16,
    parameter int FIFO_DEPTH          = 8,
    parameter int DATA_WIDTH          = 8
) (
    input  logic                           clock_i,
    input  logic                           reset_n_i,
    input  logic [DATA_WIDTH-1:0]          data_i,
    input  logic                           write_valid_i,
    output logic                           write_ready_o,
    input  logic [1:0]                     data_bits_i,
    input  logic                           parity_bit_i,
    input  logic                           parity_even_i,
    input  logic                           two_stop_bits_i,
    input  logic [CLOCK_DIVIDER_WIDTH-1:0] clock_divider_i,
`ifdef UART_TX_CTS_EN
    input  logic                           cts_n_i,
`endif
    output logic                           serial_o,
    output logic                           busy_o,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level_o
);

    localparam int CW = CLOCK_DIVIDER_WIDTH;

    tx_state_t             state_q, state_d;
    logic [CW-1:0]         div_q, div_cnt_q, div_in;
    logic [1:0]            bits_q;
    logic                  par_en_q, par_even_q, two_stop_q;
    logic [DATA_WIDTH-1:0] shreg_q, fifo_data;
    logic [2:0]            bit_idx_q;
    logic                  par_q, serial_q;
    logic                  fifo_full, fifo_empty;
    logic                  tick, load, reload, shift, start_ok, cts_ok;

`ifdef UART_TX_CTS_EN
    logic [1:0] cts_sync_q;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) cts_sync_q <= 2'b11;
        else            cts_sync_q <= {cts_sync_q[0], cts_n_i};
    end

    assign cts_ok = ~cts_sync_q[1];
`else
    assign cts_ok = 1'b1;
`endif

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock_i),
        .reset_n (reset_n_i),
        .push    (write_valid_i),
        .pop     (load),
        .wr_data (data_i),
        .rd_data (fifo_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level_o)
    );

    assign div_in   = (clock_divider_i == '0) ? CW'(1) : clock_divider_i;
    assign tick     = (div_cnt_q == '0);
    assign start_ok = !fifo_empty && cts_ok;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= TX_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        reload  = 1'b0;
        shift   = 1'b0;
        unique case (state_q)
            TX_IDLE: begin
                if (start_ok) begin
                    state_d = TX_START;
                    load    = 1'b1;
                end
            end
            TX_START: begin
                if (tick) begin
                    state_d = TX_DATA;
                    reload  = 1'b1;
                end
            end
            TX_DATA: begin
                if (tick) begin
                    reload = 1'b1;
                    shift  = 1'b1;
                    if (bit_idx_q == ({1'b0, bits_q} + 3'd4))
                        state_d = par_en_q ? TX_PARITY : TX_STOP1;
                end
            end
            TX_PARITY: begin
                if (tick) begin
                    state_d = TX_STOP1;
                    reload  = 1'b1;
                end
            end
            TX_STOP1, TX_STOP2: begin
                if (tick) begin
                    reload = 1'b1;
                    if (state_q == TX_STOP1 && two_stop_q) begin
                        state_d = TX_STOP2;
                    end else if (start_ok) begin
                        state_d = TX_START;
                        load    = 1'b1;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // A new frame captures its configuration together with the character.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            div_q      <= CW'(1);
            div_cnt_q  <= '0;
            bits_q     <= DATA_BITS_8;
            par_en_q   <= 1'b0;
            par_even_q <= 1'b0;
            two_stop_q <= 1'b0;
            shreg_q    <= '0;
            bit_idx_q  <= '0;
            par_q      <= 1'b0;
        end else if (load) begin
            div_q      <= div_in;
            div_cnt_q  <= div_in - CW'(1);
            bits_q     <= data_bits_i;
            par_en_q   <= parity_bit_i;
            par_even_q <= parity_even_i;
            two_stop_q <= two_stop_bits_i;
            shreg_q    <= fifo_data;
            bit_idx_q  <= '0;
            par_q      <= parity_of(8'(fifo_data), data_bits_i, parity_even_i);
        end else if (reload) begin
            div_cnt_q <= div_q - CW'(1);
            if (shift) begin
                shreg_q   <= shreg_q >> 1;
                bit_idx_q <= bit_idx_q + 3'd1;
            end
        end else if (!tick) begin
            div_cnt_q <= div_cnt_q - CW'(1);
        end
    end

    // The line follows the state one cycle later, from a flop.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            serial_q <= 1'b1;
        end else begin
            unique case (state_q)
                TX_START:  serial_q <= 1'b0;
                TX_DATA:   serial_q <= shreg_q[0];
                TX_PARITY: serial_q <= par_q;
                default:   serial_q <= 1'b1;
            endcase
        end
    end

    assign serial_o      = serial_q;
    assign busy_o        = (state_q != TX_IDLE) || !fifo_empty;
    assign write_ready_o = !fifo_full;

endmodule
